// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage between a fixed-latency instruction ROM and the decoder.
//   An internal PC drives sequential ROM reads. Returned words land in a
//   prefetch FIFO. The FIFO head is offered downstream on a valid/ready
//   handshake. A redirect pulse flushes the FIFO and any in-flight reads and
//   restarts fetch at a new PC. Halt stops new reads and lets the pipe drain.
//   A read is only issued when the FIFO is sure to have room for its reply.
//   Optional build macro: FETCH_STATS_EN adds the fetch_cnt/flush_cnt counters.
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned ADDR_W   = 9,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] rom_addr,
  output logic        rom_en,
  input  logic [15:0] rom_q,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ROM_LAT-1:0]  infl_vld_q, infl_vld_d;
  logic [ADDR_W-1:0]   infl_pc_q [ROM_LAT];
  logic [ADDR_W-1:0]   infl_pc_d [ROM_LAT];
  logic [15:0]         mem_data [DEPTH];
  logic [ADDR_W-1:0]   mem_pc [DEPTH];
  logic [PTR_W-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    infl_cnt;
  logic [CNT_W:0]      occupancy;
  logic                issue, push, pop, fifo_empty;
  logic                unused_redirect_hi;

  // Only the low ADDR_W bits of the redirect target are meaningful.
  assign unused_redirect_hi = ^redirect_pc[15:ADDR_W];

  // Occupancy: words already in the FIFO plus replies still in flight.
  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      infl_cnt = infl_cnt + CNT_W'(infl_vld_q[i]);
    end
    occupancy = {1'b0, count_q} + {1'b0, infl_cnt};
  end

  // Handshake and issue decisions for the current cycle.
  always_comb begin
    fifo_empty  = (count_q == '0);
    instr_valid = !fifo_empty && !redirect;
    pop         = instr_valid && instr_ready;
    push        = infl_vld_q[ROM_LAT-1];
    issue       = (state_q == ST_RUN) && !redirect &&
                  (occupancy < (CNT_W+1)'(DEPTH));
    // rom_en is also masked by rst_n so no read is requested while reset is asserted.
    rom_en      = issue && rst_n;
    rom_addr    = rom_en ? 16'(pc_q) : 16'h0000;
    instr       = fifo_empty ? 16'h0000 : mem_data[rd_q];
    instr_pc    = fifo_empty ? 16'h0000 : 16'(mem_pc[rd_q]);
  end

  // Next PC, in-flight shift register and FIFO pointers.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave it unassigned and infer a latch.
    pc_d       = pc_q;
    infl_vld_d = infl_vld_q;
    infl_pc_d  = infl_pc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;

    for (int i = ROM_LAT - 1; i > 0; i--) begin
      infl_vld_d[i] = infl_vld_q[i-1];
      infl_pc_d[i]  = infl_pc_q[i-1];
    end
    infl_vld_d[0] = issue;
    infl_pc_d[0]  = pc_q;

    if (redirect) begin
      // Flush: late ROM replies are dropped with their valid bits.
      pc_d       = redirect_pc[ADDR_W-1:0];
      infl_vld_d = '0;
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
    end else begin
      if (issue) pc_d = pc_q + ADDR_W'(1);
      if (push)  wr_d = wr_q + PTR_W'(1);
      if (pop)   rd_d = rd_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Run/drain/halt control. A redirect leaves the state untouched.
  always_comb begin
    state_d = state_q;
    if (!redirect) begin
      case (state_q)
        ST_RUN:    if (halt) state_d = ST_DRAIN;
        ST_DRAIN: begin
          if (!halt)                 state_d = ST_RUN;
          else if (infl_cnt == '0)   state_d = ST_HALTED;
        end
        ST_HALTED: if (!halt) state_d = ST_RUN;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC[ADDR_W-1:0];
      infl_vld_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) infl_pc_q[i] <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      pc_q       <= pc_d;
      infl_vld_q <= infl_vld_d;
      infl_pc_q  <= infl_pc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage: ROM word plus the address it came from.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count_q marks it empty and the outputs are masked until written.
    if (push && !redirect) begin
      mem_data[wr_q] <= rom_q;
      mem_pc[wr_q]   <= infl_pc_q[ROM_LAT-1];
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt_q, flush_cnt_q;

  // Statistics: FIFO pushes and redirects, both wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (push && !redirect) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (redirect)          flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. A table of per-cycle vectors covers
//   streaming, redirect with upper-bit masking and PC wrap. Hand-written
//   sequences cover backpressure, halt/resume and reset with a full FIFO.
//   The ROM model returns addr + 16'hA000 one cycle after a read.
module tb_instr_fetch_unit;

  localparam int DEPTH   = 4;
  localparam int ROM_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rom_addr;
  logic        rom_en;
  logic [15:0] rom_q = 16'h0000;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt = 1'b0;
`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt;
  logic [15:0] flush_cnt;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pop    = 0;
  int          n_issue  = 0;
  logic [15:0] exp_pc   = 16'h0000;

  typedef struct {
    logic        ready;
    logic        redir;
    logic [15:0] rpc;
    logic        en;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] ins;
    logic [15:0] ipc;
  } vec_t;

  vec_t vecs [16];

  instr_fetch_unit #(
    .DEPTH(DEPTH), .ROM_LAT(ROM_LAT), .ADDR_W(9), .RESET_PC(16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_addr    (rom_addr),
    .rom_en      (rom_en),
    .rom_q       (rom_q),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt)
`ifdef FETCH_STATS_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  // Single-cycle-latency ROM model.
  always @(posedge clk) begin
    if (rom_en) rom_q <= rom_word(rom_addr);
  end

  function automatic vec_t mk(input logic rd, input logic rr, input logic [15:0] rpc,
                              input logic en, input logic [15:0] addr, input logic v,
                              input logic [15:0] ins, input logic [15:0] ipc);
    vec_t r;
    r.ready = rd; r.redir = rr; r.rpc = rpc;
    r.en = en; r.addr = addr; r.valid = v; r.ins = ins; r.ipc = ipc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Sample the current cycle: score any pop against the expected sequence and count reads.
  task automatic observe();
    #1;
    if (instr_valid && instr_ready) begin
      check("seq_instr", instr, rom_word(exp_pc));
      check("seq_pc", instr_pc, exp_pc);
      exp_pc = (exp_pc + 16'd1) & 16'h01FF;
      n_pop++;
    end
    if (rom_en) n_issue++;
  endtask

  // Hold reset over two edges; returns at the start of cycle 0 after release.
  task automatic do_reset();
    rst_n = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; halt = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit   hold_ok;
    bit   got;
    int   first;

    // Stream from reset, redirect with upper bits set, redirect across the wrap.
    vecs[0]  = mk(1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    vecs[1]  = mk(1, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000, 16'h0000);
    vecs[2]  = mk(1, 0, 16'h0000, 1, 16'h0002, 1, 16'hA000, 16'h0000);
    vecs[3]  = mk(1, 0, 16'h0000, 1, 16'h0003, 1, 16'hA001, 16'h0001);
    vecs[4]  = mk(1, 0, 16'h0000, 1, 16'h0004, 1, 16'hA002, 16'h0002);
    vecs[5]  = mk(1, 1, 16'hFE40, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    vecs[6]  = mk(1, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 16'h0000);
    vecs[7]  = mk(1, 0, 16'h0000, 1, 16'h0041, 0, 16'h0000, 16'h0000);
    vecs[8]  = mk(1, 0, 16'h0000, 1, 16'h0042, 1, 16'hA040, 16'h0040);
    vecs[9]  = mk(1, 1, 16'h01FE, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    vecs[10] = mk(1, 0, 16'h0000, 1, 16'h01FE, 0, 16'h0000, 16'h0000);
    vecs[11] = mk(1, 0, 16'h0000, 1, 16'h01FF, 0, 16'h0000, 16'h0000);
    vecs[12] = mk(1, 0, 16'h0000, 1, 16'h0000, 1, 16'hA1FE, 16'h01FE);
    vecs[13] = mk(1, 0, 16'h0000, 1, 16'h0001, 1, 16'hA1FF, 16'h01FF);
    vecs[14] = mk(1, 0, 16'h0000, 1, 16'h0002, 1, 16'hA000, 16'h0000);
    vecs[15] = mk(1, 0, 16'h0000, 1, 16'h0003, 1, 16'hA001, 16'h0001);

    // Reset state.
    rst_n = 1'b0; instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_rom_en", rom_en, 1'b0);
    check("rst_rom_addr", rom_addr, 16'h0000);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 16'h0000);
    check("rst_instr_pc", instr_pc, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven cycle vectors.
    for (int i = 0; i < 16; i++) begin
      instr_ready = vecs[i].ready;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      halt        = 1'b0;
      #1;
      check($sformatf("v%0d_rom_en", i), rom_en, vecs[i].en);
      if (vecs[i].en) check($sformatf("v%0d_rom_addr", i), rom_addr, vecs[i].addr);
      check($sformatf("v%0d_instr_valid", i), instr_valid, vecs[i].valid);
      if (vecs[i].valid) begin
        check($sformatf("v%0d_instr", i), instr, vecs[i].ins);
        check($sformatf("v%0d_instr_pc", i), instr_pc, vecs[i].ipc);
      end
`ifdef FETCH_STATS_EN
      if (i == 15) begin
        check("stats_fetch_cnt", fetch_cnt, 16'd10);
        check("stats_flush_cnt", flush_cnt, 16'd2);
      end
`endif
      next_cycle();
    end
    redirect = 1'b0;

    // Backpressure: exactly DEPTH reads, head holds, then lossless drain.
    do_reset();
    instr_ready = 1'b0; exp_pc = 16'h0000; n_pop = 0; n_issue = 0; hold_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      observe();
      if (c >= 2 && !(instr_valid && instr == 16'hA000 && instr_pc == 16'h0000)) hold_ok = 1'b0;
      if (c == 9) check("bp_rom_en_idle", rom_en, 1'b0);
      next_cycle();
    end
    check("bp_issue_count", n_issue, DEPTH);
    check("bp_head_hold", hold_ok, 1'b1);
    instr_ready = 1'b1;
    for (int c = 0; c < 40 && n_pop < 10; c++) begin
      observe();
      next_cycle();
    end
    check("bp_pop_count", n_pop, 10);

    // Halt mid-stream, drain, resume at the next sequential PC.
    do_reset();
    instr_ready = 1'b1; exp_pc = 16'h0000; n_pop = 0; n_issue = 0;
    for (int c = 0; c < 4; c++) begin
      observe();
      next_cycle();
    end
    halt = 1'b1;
    observe();
    check("halt_edge_rom_en", rom_en, 1'b1);
    check("halt_edge_rom_addr", rom_addr, 16'h0004);
    next_cycle();
    n_issue = 0;
    for (int c = 0; c < 10; c++) begin
      observe();
      next_cycle();
    end
    check("halt_no_issue", n_issue, 0);
    check("halt_drained_pops", n_pop, 5);
    check("halt_valid_low", instr_valid, 1'b0);
    halt = 1'b0; got = 1'b0;
    for (int c = 0; c < 4 && !got; c++) begin
      observe();
      if (rom_en) begin
        got = 1'b1;
        check("resume_rom_addr", rom_addr, 16'h0005);
      end
      next_cycle();
    end
    check("resume_seen", got, 1'b1);
    for (int c = 0; c < 20 && n_pop < 8; c++) begin
      observe();
      next_cycle();
    end
    check("resume_pop_count", n_pop, 8);

    // Reset for one cycle with the FIFO full.
    do_reset();
    instr_ready = 1'b0;
    repeat (8) next_cycle();
    check("full_pre_valid", instr_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", instr_valid, 1'b0);
    check("mid_rst_rom_en", rom_en, 1'b0);
    check("mid_rst_instr", instr, 16'h0000);
    check("mid_rst_instr_pc", instr_pc, 16'h0000);
`ifdef FETCH_STATS_EN
    check("mid_rst_fetch_cnt", fetch_cnt, 16'd0);
    check("mid_rst_flush_cnt", flush_cnt, 16'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1; instr_ready = 1'b1; exp_pc = 16'h0000; n_pop = 0; first = -1;
    for (int c = 0; c < 8 && n_pop == 0; c++) begin
      observe();
      if (n_pop != 0) first = c;
      next_cycle();
    end
    check("rst_first_valid_cycle", first, ROM_LAT + 1);
    for (int c = 0; c < 10 && n_pop < 4; c++) begin
      observe();
      next_cycle();
    end
    check("rst_refetch_pops", n_pop, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
